fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the 16-bit RISC-Z core.
- Drives the instruction memory's `enable` and 10-bit `pc` inputs and captures the returned word into a small prefetch queue.
- Presents fetched instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects (queue flush) and detects fetch past the end of instruction memory.

---
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer control, imem and decode handshake bundle
interface fetch_sequencer_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
);
    logic               start;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_en;
    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_ready;
    logic               busy;
    logic               fault;

    modport master (
        input  start, redirect, redirect_pc, imem_data, instr_ready,
        output imem_en, imem_pc, instr_valid, instr, instr_pc, busy, fault
    );

    modport slave (
        output start, redirect, redirect_pc, imem_data, instr_ready,
        input  imem_en, imem_pc, instr_valid, instr, instr_pc, busy, fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with prefetch queue, redirect flush and end-of-memory fault
module fetch_sequencer #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 16,
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 1000,
    parameter int RESET_PC  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0]  MEM_LIMIT = PC_W'(MEM_WORDS);
    localparam logic [PC_W-1:0]  PC_INIT   = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FAULT
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    fetch_pc;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PC_W-1:0]    q_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               busy_q;
    logic               fault_q;

    logic in_range;
    logic pop;
    logic push;

    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    always_comb begin
        in_range = (fetch_pc < MEM_LIMIT);
        pop      = (count != '0) && bus.instr_ready;
        push     = (state == S_FETCH) && in_range && ((count < DEPTH_C) || pop)
                   && !bus.redirect;
    end

    assign bus.imem_en     = push;
    assign bus.imem_pc     = fetch_pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = q_instr[rd_ptr];
    assign bus.instr_pc    = q_pc[rd_ptr];
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            q_instr[wr_ptr] <= bus.imem_data;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= PC_INIT;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_FETCH;
                        busy_q <= 1'b1;
                    end
                end
                S_FETCH, S_FAULT: begin
                    if (bus.redirect) begin
                        rd_ptr   <= '0;
                        wr_ptr   <= '0;
                        count    <= '0;
                        fetch_pc <= bus.redirect_pc;
                        if (bus.redirect_pc < MEM_LIMIT) begin
                            state   <= S_FETCH;
                            busy_q  <= 1'b1;
                            fault_q <= 1'b0;
                        end else begin
                            state   <= S_FAULT;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end
                    end else if (state == S_FETCH) begin
                        if (push) begin
                            wr_ptr   <= wr_ptr + PTR_W'(1);
                            fetch_pc <= fetch_pc + PC_W'(1);
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                        if (push && !pop) begin
                            count <= count + CNT_W'(1);
                        end else if (pop && !push) begin
                            count <= count - CNT_W'(1);
                        end
                        // Fault only once everything fetched before the end has drained.
                        if (!in_range && (count == '0)) begin
                            state   <= S_FAULT;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector table, corner sequences and random run against a queue model
module tb_fetch_sequencer;
    localparam int MEMW = 1000;
    localparam int DEP  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_W(10), .INSTR_W(16)) bus ();

    fetch_sequencer #(
        .PC_W(10), .INSTR_W(16), .DEPTH(DEP), .MEM_WORDS(MEMW), .RESET_PC(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_data = 16'hA000 + {6'd0, bus.imem_pc};

    typedef struct {
        bit rst_n;
        bit start;
        bit redir;
        int rpc;
        bit rdy;
        bit e_en;
        int e_pc;
        bit e_v;
        int e_ipc;
        bit e_busy;
        bit e_fault;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    int m_state;
    int m_pc;
    int mq[$];

    function automatic vec_t mk(bit r, bit s, bit rd, int rpc, bit rdy,
                                bit en, int pc, bit v, int ipc, bit b, bit f);
        vec_t t;
        t.rst_n = r; t.start = s; t.redir = rd; t.rpc = rpc; t.rdy = rdy;
        t.e_en = en; t.e_pc = pc; t.e_v = v; t.e_ipc = ipc; t.e_busy = b; t.e_fault = f;
        return t;
    endfunction

    function automatic logic [39:0] pack(bit en, int pc, bit v, int ipc, bit b, bit f);
        logic [9:0]  p  = pc[9:0];
        logic [9:0]  ip = v ? ipc[9:0] : 10'd0;
        logic [15:0] iw = v ? 16'(32'hA000 + ipc) : 16'd0;
        return {en, p, v, ip, iw, b, f};
    endfunction

    function automatic logic [39:0] dut_out();
        return pack(bus.imem_en, int'(bus.imem_pc), bus.instr_valid, int'(bus.instr_pc),
                    bus.busy, bus.fault)
               | {24'd0, (bus.instr_valid ? bus.instr : 16'd0)}
               ^ {24'd0, (bus.instr_valid ? 16'(32'hA000 + int'(bus.instr_pc)) : 16'd0)};
    endfunction

    task automatic compare(string name, logic [39:0] got, logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {en,pc,v,ipc,instr,busy,fault}=%h required %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        mq.delete();
    endtask

    function automatic logic [39:0] model_out(bit rd, bit rdy);
        bit v   = (mq.size() != 0);
        bit pop = v && rdy;
        bit en  = (m_state == 1) && (m_pc < MEMW) && ((mq.size() < DEP) || pop) && !rd;
        return pack(en, m_pc, v, v ? mq[0] : 0, m_state == 1, m_state == 2);
    endfunction

    task automatic model_step(bit r, bit s, bit rd, int rpc, bit rdy);
        bit popped;
        bit pushed;
        if (!r) begin
            model_reset();
        end else if (m_state == 0) begin
            if (s) m_state = 1;
        end else if (rd) begin
            mq.delete();
            m_pc    = rpc;
            m_state = (rpc < MEMW) ? 1 : 2;
        end else if (m_state == 1) begin
            if (m_pc >= MEMW && mq.size() == 0) begin
                m_state = 2;
            end else begin
                popped = (mq.size() != 0) && rdy;
                pushed = (m_pc < MEMW) && ((mq.size() < DEP) || popped);
                if (popped) void'(mq.pop_front());
                if (pushed) begin
                    mq.push_back(m_pc);
                    m_pc = m_pc + 1;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1ns later, then let the rising edge act.
    task automatic run_vec(string name, vec_t t, bit use_model);
        @(negedge clk);
        rst_n           = t.rst_n;
        bus.start       = t.start;
        bus.redirect    = t.redir;
        bus.redirect_pc = t.rpc[9:0];
        bus.instr_ready = t.rdy;
        #1;
        if (use_model)
            compare(name, dut_out(), model_out(t.redir, t.rdy));
        else
            compare(name, dut_out(), pack(t.e_en, t.e_pc, t.e_v, t.e_ipc, t.e_busy, t.e_fault));
        @(posedge clk);
        model_step(t.rst_n, t.start, t.redir, t.rpc, t.rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; bus.start = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        @(posedge clk);
        model_reset();
    endtask

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        model_reset();

        //            rst s rd rpc  rdy  en pc   v ipc  b f
        tbl.push_back(mk(1, 0, 1, 50,  1,  0, 0,   0, 0,   0, 0));
        tbl.push_back(mk(1, 1, 0, 0,   0,  0, 0,   0, 0,   0, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0,  1, 0,   0, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0,  1, 1,   1, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0,  1, 2,   1, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0,  1, 3,   1, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0,  0, 4,   1, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 4,   1, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 5,   1, 1,   1, 0));
        tbl.push_back(mk(1, 0, 1, 100, 1,  0, 6,   1, 2,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 100, 0, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 101, 1, 100, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1000,0,  0, 102, 1, 101, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  0, 1000,0, 0,   0, 1));
        tbl.push_back(mk(1, 0, 1, 996, 1,  0, 1000,0, 0,   0, 1));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 996, 0, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 997, 1, 996, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 998, 1, 997, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 999, 1, 998, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  0, 1000,1, 999, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  0, 1000,0, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  0, 1000,0, 0,   0, 1));
        tbl.push_back(mk(1, 0, 1, 10,  1,  0, 1000,0, 0,   0, 1));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 10,  0, 0,   1, 0));
        tbl.push_back(mk(1, 0, 0, 0,   1,  1, 11,  1, 10,  1, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Reset with three entries queued and a redirect asserted on the same edge.
        do_reset();
        run_vec("mid_start", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        run_vec("mid_q0",    mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), 1'b0);
        run_vec("mid_q1",    mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0), 1'b0);
        run_vec("mid_q2",    mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 1, 0), 1'b0);
        run_vec("mid_rst",   mk(0, 0, 1, 77, 1, 0, 3, 1, 0, 1, 0), 1'b0);
        run_vec("post_rst",  mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        run_vec("refetch0",  mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0), 1'b0);
        run_vec("refetch1",  mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0), 1'b0);

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            vec_t t;
            t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            t.rst_n = ($urandom_range(0, 299) != 0);
            t.start = ($urandom_range(0, 7) == 0);
            t.redir = ($urandom_range(0, 19) == 0);
            t.rpc   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(990, 1005))
                                                  : int'($urandom_range(0, 999));
            t.rdy   = ($urandom_range(0, 3) != 0);
            run_vec($sformatf("rand%0d", c), t, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
